// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the register-file writeback path.
//   XLEN       : data width of a register
//   REG_ADDR_W : width of a register index
//   NUM_REGS   : number of architectural registers
//   wb_req_t   : one pending register write {destination, data}
// ---------------------------------------------------------------------------
package riscv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_req_t;

endpackage

// File: rtl/wb_result_fifo.sv
// ---------------------------------------------------------------------------
// wb_result_fifo
// Circular FIFO of pending register writes (wb_req_t) used to buffer
// long-latency load results until they win the register file write port.
// Ports:
//   clk, rst   : clock, synchronous active-high reset (empties the FIFO)
//   push       : enqueue push_data (ignored when full unless also popping)
//   push_data  : entry to enqueue
//   pop        : dequeue the head entry (ignored when empty)
//   head       : current oldest entry
//   full/empty : occupancy flags, derived from the registered count only
//   count      : number of valid entries
// ---------------------------------------------------------------------------
module wb_result_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  wb_req_t                  push_data,
    input  logic                     pop,
    output wb_req_t                  head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_req_t            mem_q [DEPTH];
    wb_req_t            mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               do_push;
    logic               do_pop;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    // Pointers wrap naturally because DEPTH is a power of two. A push into
    // a full FIFO is only honoured when the head leaves in the same cycle.
    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible through count.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/regfile_writeback_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_writeback_arbiter
// Sole writer of the register file write port. Merges single-cycle ALU
// results with buffered memory load results, prevents load starvation and
// keeps a pending-load scoreboard for the hazard logic.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   alu_valid/rd/data        : ALU result offered this cycle
//   alu_stall                : ALU result not consumed this cycle (comb.)
//   mem_valid/rd/data        : load result offered; accepted when mem_ready
//   mem_ready                : load FIFO has room
//   issue_load/issue_rd      : a load has been issued to issue_rd
//   busy_vec                 : bit r set while a load to xr is pending
//   RegWrite/write_address/
//   write_data               : registered register file write port
//   waw_err                  : sticky; ALU wrote a register with a load pending
// Optional feature (macro WB_BYPASS_EN):
//   rs1_addr/rs2_addr, rf_data_1/rf_data_2 in, op_data_1/op_data_2 out;
//   forwards the write port onto the operand read path in the same cycle.
// ---------------------------------------------------------------------------
module regfile_writeback_arbiter
    import riscv_pkg::*;
#(
    parameter int MEM_FIFO_DEPTH = 4,
    parameter int STARVE_LIMIT   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]       alu_data,
    output logic                  alu_stall,
    input  logic                  mem_valid,
    output logic                  mem_ready,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic [XLEN-1:0]       mem_data,
    input  logic                  issue_load,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    output logic [NUM_REGS-1:0]   busy_vec,
    output logic                  RegWrite,
    output logic [REG_ADDR_W-1:0] write_address,
    output logic [XLEN-1:0]       write_data,
`ifdef WB_BYPASS_EN
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    input  logic [XLEN-1:0]       rf_data_1,
    input  logic [XLEN-1:0]       rf_data_2,
    output logic [XLEN-1:0]       op_data_1,
    output logic [XLEN-1:0]       op_data_2,
`endif
    output logic                  waw_err
);

    localparam int SC_W = $clog2(STARVE_LIMIT + 1);

    wb_req_t                     fifo_head;
    wb_req_t                     fifo_in;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic [$clog2(MEM_FIFO_DEPTH):0] fifo_count;
    logic                        fifo_push;
    logic                        fifo_pop;

    logic                        alu_win;
    logic                        fifo_win;

    logic [SC_W-1:0]             starve_cnt_q, starve_cnt_d;
    logic [NUM_REGS-1:0]         busy_q, busy_d;
    logic                        reg_write_q, reg_write_d;
    logic [REG_ADDR_W-1:0]       write_address_q, write_address_d;
    logic [XLEN-1:0]             write_data_q, write_data_d;
    logic                        waw_err_q, waw_err_d;

    assign fifo_in = '{rd: mem_rd, data: mem_data};

    wb_result_fifo #(
        .DEPTH (MEM_FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (fifo_in),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // mem_ready looks only at the registered occupancy so there is no
    // combinational path from the arbitration result back to the load unit.
    assign mem_ready = !fifo_full;
    assign fifo_push = mem_valid && mem_ready;

    // Arbitration: ALU has priority unless it has starved the FIFO for
    // STARVE_LIMIT consecutive cycles, in which case the head gets one slot.
    always_comb begin
        alu_stall = (starve_cnt_q == SC_W'(STARVE_LIMIT)) && alu_valid && !fifo_empty;
        alu_win   = alu_valid && !alu_stall;
        fifo_win  = !alu_win && !fifo_empty;
        fifo_pop  = fifo_win;

        starve_cnt_d = '0;
        if (alu_win && !fifo_empty) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end

        reg_write_d     = 1'b0;
        write_address_d = write_address_q;
        write_data_d    = write_data_q;
        if (alu_win) begin
            reg_write_d     = (alu_rd != '0);
            write_address_d = alu_rd;
            write_data_d    = alu_data;
        end else if (fifo_win) begin
            reg_write_d     = (fifo_head.rd != '0);
            write_address_d = fifo_head.rd;
            write_data_d    = fifo_head.data;
        end

        // Clear on commit first so a same-cycle issue to the same register
        // leaves the bit set: the new load is still outstanding.
        busy_d = busy_q;
        if (fifo_win) begin
            busy_d[fifo_head.rd] = 1'b0;
        end
        if (issue_load && (issue_rd != '0)) begin
            busy_d[issue_rd] = 1'b1;
        end

        waw_err_d = waw_err_q;
        if (alu_win && (alu_rd != '0) && busy_q[alu_rd]) begin
            waw_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_q    <= '0;
            busy_q          <= '0;
            reg_write_q     <= 1'b0;
            write_address_q <= '0;
            write_data_q    <= '0;
            waw_err_q       <= 1'b0;
        end else begin
            starve_cnt_q    <= starve_cnt_d;
            busy_q          <= busy_d;
            reg_write_q     <= reg_write_d;
            write_address_q <= write_address_d;
            write_data_q    <= write_data_d;
            waw_err_q       <= waw_err_d;
        end
    end

    assign busy_vec      = busy_q;
    assign RegWrite      = reg_write_q;
    assign write_address = write_address_q;
    assign write_data    = write_data_q;
    assign waw_err       = waw_err_q;

`ifdef WB_BYPASS_EN
    // The register file is written at the end of this cycle, so a read of
    // the same register now would see stale data; forward the write port.
    always_comb begin
        op_data_1 = rf_data_1;
        op_data_2 = rf_data_2;
        if (reg_write_q && (write_address_q == rs1_addr) && (rs1_addr != '0)) begin
            op_data_1 = write_data_q;
        end
        if (reg_write_q && (write_address_q == rs2_addr) && (rs2_addr != '0)) begin
            op_data_2 = write_data_q;
        end
    end
`endif

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_writeback_arbiter
// Directed vectors for the writeback arbiter: a table of one-cycle vectors
// plus hand-written sequences for reset mid-FIFO and load starvation.
// ---------------------------------------------------------------------------
module tb_regfile_writeback_arbiter;

    logic        clk;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_stall;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        issue_load;
    logic [4:0]  issue_rd;
    logic [31:0] busy_vec;
    logic        RegWrite;
    logic [4:0]  write_address;
    logic [31:0] write_data;
    logic        waw_err;
`ifdef WB_BYPASS_EN
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rf_data_1;
    logic [31:0] rf_data_2;
    logic [31:0] op_data_1;
    logic [31:0] op_data_2;
`endif

    int n_compared;
    int n_mismatched;

    regfile_writeback_arbiter #(
        .MEM_FIFO_DEPTH (4),
        .STARVE_LIMIT   (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .alu_valid     (alu_valid),
        .alu_rd        (alu_rd),
        .alu_data      (alu_data),
        .alu_stall     (alu_stall),
        .mem_valid     (mem_valid),
        .mem_ready     (mem_ready),
        .mem_rd        (mem_rd),
        .mem_data      (mem_data),
        .issue_load    (issue_load),
        .issue_rd      (issue_rd),
        .busy_vec      (busy_vec),
        .RegWrite      (RegWrite),
        .write_address (write_address),
        .write_data    (write_data),
`ifdef WB_BYPASS_EN
        .rs1_addr      (rs1_addr),
        .rs2_addr      (rs2_addr),
        .rf_data_1     (rf_data_1),
        .rf_data_2     (rf_data_2),
        .op_data_1     (op_data_1),
        .op_data_2     (op_data_2),
`endif
        .waw_err       (waw_err)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One cycle of stimulus and the outputs expected around it: alu_stall
    // and mem_ready before the edge, the registered outputs after it.
    typedef struct {
        string       name;
        logic        alu_valid;
        logic [4:0]  alu_rd;
        logic [31:0] alu_data;
        logic        mem_valid;
        logic [4:0]  mem_rd;
        logic [31:0] mem_data;
        logic        issue_load;
        logic [4:0]  issue_rd;
        logic        exp_stall;
        logic        exp_ready;
        logic        exp_rw;
        logic [4:0]  exp_addr;
        logic [31:0] exp_data;
        logic [31:0] exp_busy;
        logic        exp_waw;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mkVec(
        input string       name,
        input logic        av, input logic [4:0] ard, input logic [31:0] adat,
        input logic        mv, input logic [4:0] mrd, input logic [31:0] mdat,
        input logic        il, input logic [4:0] ird,
        input logic        e_stall, input logic e_ready,
        input logic        e_rw, input logic [4:0] e_addr, input logic [31:0] e_data,
        input logic [31:0] e_busy, input logic e_waw);
        vec_t v;
        v.name = name;
        v.alu_valid = av;  v.alu_rd = ard;  v.alu_data = adat;
        v.mem_valid = mv;  v.mem_rd = mrd;  v.mem_data = mdat;
        v.issue_load = il; v.issue_rd = ird;
        v.exp_stall = e_stall; v.exp_ready = e_ready;
        v.exp_rw = e_rw; v.exp_addr = e_addr; v.exp_data = e_data;
        v.exp_busy = e_busy; v.exp_waw = e_waw;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        alu_valid  = v.alu_valid;
        alu_rd     = v.alu_rd;
        alu_data   = v.alu_data;
        mem_valid  = v.mem_valid;
        mem_rd     = v.mem_rd;
        mem_data   = v.mem_data;
        issue_load = v.issue_load;
        issue_rd   = v.issue_rd;
    endtask

    task automatic driveIdle();
        alu_valid  = 1'b0;
        alu_rd     = '0;
        alu_data   = '0;
        mem_valid  = 1'b0;
        mem_rd     = '0;
        mem_data   = '0;
        issue_load = 1'b0;
        issue_rd   = '0;
    endtask

    // Advance to just after the next rising edge.
    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Registered write port check; address/data only matter when writing.
    task automatic checkWrite(input string name, input logic e_rw,
                              input logic [4:0] e_addr, input logic [31:0] e_data);
        checkOutput({name, ".RegWrite"}, {31'd0, RegWrite}, {31'd0, e_rw});
        if (e_rw) begin
            checkOutput({name, ".write_address"}, {27'd0, write_address}, {27'd0, e_addr});
            checkOutput({name, ".write_data"}, write_data, e_data);
        end
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        rst = 1'b1;
        driveIdle();
`ifdef WB_BYPASS_EN
        rs1_addr  = '0;
        rs2_addr  = '0;
        rf_data_1 = '0;
        rf_data_2 = '0;
`endif

        // ---------------- reset state ----------------
        repeat (2) stepCycle();
        checkOutput("reset.RegWrite", {31'd0, RegWrite}, 32'd0);
        checkOutput("reset.write_address", {27'd0, write_address}, 32'd0);
        checkOutput("reset.write_data", write_data, 32'd0);
        checkOutput("reset.busy_vec", busy_vec, 32'd0);
        checkOutput("reset.waw_err", {31'd0, waw_err}, 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("reset.mem_ready", {31'd0, mem_ready}, 32'd1);

        // ---------------- vector table ----------------
        //                  name        av ard  adat           mv mrd  mdat          il ird  stl rdy rw addr  data          busy          waw
        vecs.push_back(mkVec("idle",     0, 0,  32'h0,          0, 0,  32'h0,         0, 0,   0,  1,  0, 0,   32'h0,         32'h0,        0));
        vecs.push_back(mkVec("issue7",   0, 0,  32'h0,          0, 0,  32'h0,         1, 7,   0,  1,  0, 0,   32'h0,         32'h80,       0));
        vecs.push_back(mkVec("wait7",    0, 0,  32'h0,          0, 0,  32'h0,         0, 0,   0,  1,  0, 0,   32'h0,         32'h80,       0));
        vecs.push_back(mkVec("alu5",     1, 5,  32'hDEADBEEF,   0, 0,  32'h0,         0, 0,   0,  1,  1, 5,   32'hDEADBEEF,  32'h80,       0));
        vecs.push_back(mkVec("mem7",     0, 0,  32'h0,          1, 7,  32'h1234,      0, 0,   0,  1,  0, 0,   32'h0,         32'h80,       0));
        vecs.push_back(mkVec("commit7",  0, 0,  32'h0,          0, 0,  32'h0,         0, 0,   0,  1,  1, 7,   32'h1234,      32'h0,        0));
        vecs.push_back(mkVec("after7",   0, 0,  32'h0,          0, 0,  32'h0,         0, 0,   0,  1,  0, 0,   32'h0,         32'h0,        0));
        vecs.push_back(mkVec("alu_x0",   1, 0,  32'h11,         0, 0,  32'h0,         0, 0,   0,  1,  0, 0,   32'h0,         32'h0,        0));
        vecs.push_back(mkVec("mem_x0",   0, 0,  32'h0,          1, 0,  32'h22,        0, 0,   0,  1,  0, 0,   32'h0,         32'h0,        0));
        vecs.push_back(mkVec("pop_x0",   0, 0,  32'h0,          0, 0,  32'h0,         0, 0,   0,  1,  0, 0,   32'h0,         32'h0,        0));
        vecs.push_back(mkVec("mem4",     0, 0,  32'h0,          1, 4,  32'h44,        0, 0,   0,  1,  0, 0,   32'h0,         32'h0,        0));
        vecs.push_back(mkVec("commit4",  0, 0,  32'h0,          0, 0,  32'h0,         0, 0,   0,  1,  1, 4,   32'h44,        32'h0,        0));
        vecs.push_back(mkVec("issue3",   0, 0,  32'h0,          0, 0,  32'h0,         1, 3,   0,  1,  0, 0,   32'h0,         32'h8,        0));
        vecs.push_back(mkVec("waw3",     1, 3,  32'h33,         0, 0,  32'h0,         0, 0,   0,  1,  1, 3,   32'h33,        32'h8,        1));
        vecs.push_back(mkVec("alu6",     1, 6,  32'h66,         0, 0,  32'h0,         0, 0,   0,  1,  1, 6,   32'h66,        32'h8,        1));
        vecs.push_back(mkVec("mem3",     0, 0,  32'h0,          1, 3,  32'h3030,      0, 0,   0,  1,  0, 0,   32'h0,         32'h8,        1));
        vecs.push_back(mkVec("commit3",  0, 0,  32'h0,          0, 0,  32'h0,         0, 0,   0,  1,  1, 3,   32'h3030,      32'h0,        1));
        vecs.push_back(mkVec("issue8",   0, 0,  32'h0,          0, 0,  32'h0,         1, 8,   0,  1,  0, 0,   32'h0,         32'h100,      1));
        vecs.push_back(mkVec("mem8",     0, 0,  32'h0,          1, 8,  32'h88,        0, 0,   0,  1,  0, 0,   32'h0,         32'h100,      1));
        vecs.push_back(mkVec("setclr8",  0, 0,  32'h0,          0, 0,  32'h0,         1, 8,   0,  1,  1, 8,   32'h88,        32'h100,      1));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            #1;
            checkOutput({vecs[i].name, ".alu_stall"}, {31'd0, alu_stall}, {31'd0, vecs[i].exp_stall});
            checkOutput({vecs[i].name, ".mem_ready"}, {31'd0, mem_ready}, {31'd0, vecs[i].exp_ready});
            @(posedge clk);
            #1;
            checkWrite(vecs[i].name, vecs[i].exp_rw, vecs[i].exp_addr, vecs[i].exp_data);
            checkOutput({vecs[i].name, ".busy_vec"}, busy_vec, vecs[i].exp_busy);
            checkOutput({vecs[i].name, ".waw_err"}, {31'd0, waw_err}, {31'd0, vecs[i].exp_waw});
        end

`ifdef WB_BYPASS_EN
        // ---------------- same-cycle forwarding ----------------
        driveIdle();
        alu_valid = 1'b1;
        alu_rd    = 5'd9;
        alu_data  = 32'hA5A5A5A5;
        stepCycle();
        driveIdle();
        rs1_addr  = 5'd9;
        rf_data_1 = 32'h0;
        rs2_addr  = 5'd0;
        rf_data_2 = 32'h5555AAAA;
        #1;
        checkOutput("bypass.op_data_1", op_data_1, 32'hA5A5A5A5);
        checkOutput("bypass.op_data_2", op_data_2, 32'h5555AAAA);
        stepCycle();
        checkOutput("bypass.no_write", op_data_1, 32'h0);
`endif

        // ---------------- reset with the FIFO occupied ----------------
        // busy_vec holds x8 from the table; ALU keeps winning so loads stay queued.
        driveIdle();
        alu_valid  = 1'b1;
        alu_rd     = 5'd1;
        alu_data   = 32'h1;
        mem_valid  = 1'b1;
        mem_rd     = 5'd9;
        mem_data   = 32'h9;
        issue_load = 1'b1;
        issue_rd   = 5'd10;
        stepCycle();
        checkWrite("midrst.a", 1'b1, 5'd1, 32'h1);
        checkOutput("midrst.a.busy_vec", busy_vec, 32'h0000_0500);
        issue_load = 1'b0;
        alu_data   = 32'h2;
        mem_rd     = 5'd11;
        mem_data   = 32'hB;
        stepCycle();
        checkWrite("midrst.b", 1'b1, 5'd1, 32'h2);
        driveIdle();
        rst = 1'b1;
        stepCycle();
        rst = 1'b0;
        checkOutput("midrst.busy_vec", busy_vec, 32'h0);
        checkOutput("midrst.waw_err", {31'd0, waw_err}, 32'd0);
        checkOutput("midrst.RegWrite", {31'd0, RegWrite}, 32'd0);
        checkOutput("midrst.mem_ready", {31'd0, mem_ready}, 32'd1);
        stepCycle();
        checkOutput("midrst.drained", {31'd0, RegWrite}, 32'd0);

        // ---------------- backpressure, starvation and ordering ----------------
        // Four loads arrive while the ALU is busy every cycle. The FIFO is
        // non-empty from cycle 1, so after eight ALU wins (cycles 1..8) the
        // ALU is stalled in cycle 9 and the oldest load commits.
        begin
            int k;
            k = 0;
            for (int c = 0; c < 12; c++) begin
                alu_valid  = 1'b1;
                alu_rd     = 5'd1;
                alu_data   = 32'hA000_0000 + k;
                mem_valid  = (c < 4);
                mem_rd     = 5'(20 + c);
                mem_data   = 32'hB000_0000 + c;
                issue_load = 1'b0;
                #1;
                checkOutput($sformatf("starve.c%0d.alu_stall", c), {31'd0, alu_stall},
                            {31'd0, (c == 9)});
                checkOutput($sformatf("starve.c%0d.mem_ready", c), {31'd0, mem_ready},
                            {31'd0, (c < 4) || (c >= 10)});
                @(posedge clk);
                #1;
                if (c == 9) begin
                    checkWrite("starve.head0", 1'b1, 5'd20, 32'hB000_0000);
                end else begin
                    checkWrite($sformatf("starve.c%0d", c), 1'b1, 5'd1, 32'hA000_0000 + k);
                    k++;
                end
            end
            driveIdle();
            for (int d = 1; d < 4; d++) begin
                stepCycle();
                checkWrite($sformatf("drain.%0d", d), 1'b1, 5'(20 + d), 32'hB000_0000 + d);
            end
            stepCycle();
            checkOutput("drain.empty", {31'd0, RegWrite}, 32'd0);
            checkOutput("drain.mem_ready", {31'd0, mem_ready}, 32'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
